ddr2_mem_model: RTL and testbench

DDR2_MEM_MODEL -- requirements
Module: ddr2_mem_model

---
 rtl/ddr2_pkg.sv | 32 +++
 rtl/ddr2_bank_fsm.sv | 41 ++++
 rtl/ddr2_mem_model.sv | 224 ++++++++++++++++++++++
 tb/tb_ddr2_mem_model.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr2_pkg
// Brief   : Shared command, error-code and bank-state encodings for the
//           DDR2 behavioural memory model.
// Revision: 1.0
// ============================================================================
package ddr2_pkg;

    // Encodings are {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_NOP = 4'b0111
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ACT_OPEN = 3'd1,
        ERR_NOT_OPEN = 3'd2,
        ERR_BUSY     = 3'd3
    } err_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/ddr2_bank_fsm.sv
`default_nettype none
// ============================================================================
// Module  : ddr2_bank_fsm
// Brief   : Per-bank IDLE/ACTIVE tracker with open-row register.
// Revision: 1.0
// ============================================================================
module ddr2_bank_fsm
    import ddr2_pkg::*;
#(
    parameter int ROW_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_act,
    input  logic                 i_pre,
    input  logic [ROW_WIDTH-1:0] i_row,
    output bank_state_e          o_state,
    output logic [ROW_WIDTH-1:0] o_open_row
);

    bank_state_e          r_state;
    logic [ROW_WIDTH-1:0] r_open_row;

    // Precharge wins so an auto-precharge close is never lost
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= BANK_IDLE;
            r_open_row <= '0;
        end else if (i_pre) begin
            r_state    <= BANK_IDLE;
        end else if (i_act) begin
            r_state    <= BANK_ACTIVE;
            r_open_row <= i_row;
        end
    end

    assign o_state    = r_state;
    assign o_open_row = r_open_row;

endmodule
`default_nettype wire

// File: rtl/ddr2_mem_model.sv
`default_nettype none
// ============================================================================
// Module  : ddr2_mem_model
// Brief   : Cycle-level DDR2-style memory model: bank FSMs, single burst
//           engine with CAS latency, byte-masked writes, error reporting.
// Revision: 1.0
// ============================================================================
module ddr2_mem_model
    import ddr2_pkg::*;
#(
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH  = 4,
    parameter int COL_WIDTH  = 5,
    parameter int ADDR_WIDTH = 13,
    parameter int DQ_WIDTH   = 16,
    parameter int CL         = 4,
    parameter int BL         = 8
) (
    input  logic                    ck,
    input  logic                    reset_n,
    input  logic                    cke,
    input  logic                    cs_n,
    input  logic                    ras_n,
    input  logic                    cas_n,
    input  logic                    we_n,
    input  logic [BANK_WIDTH-1:0]   ba,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DQ_WIDTH-1:0]     dq_in,
    input  logic [DQ_WIDTH/8-1:0]   dm,
    output logic [DQ_WIDTH-1:0]     dq_out,
    output logic                    dq_oe,
    output logic                    err,
    output logic [2:0]              err_code
);

    localparam int c_nbank = 2 ** BANK_WIDTH;
    localparam int c_idx_w = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int c_depth = 2 ** c_idx_w;
    localparam int c_cnt_w = 5;
    localparam logic [c_cnt_w-1:0]   c_rd_first = c_cnt_w'(CL);
    localparam logic [c_cnt_w-1:0]   c_wr_first = c_cnt_w'(CL - 1);
    localparam logic [c_cnt_w-1:0]   c_rd_last  = c_cnt_w'(CL + BL - 1);
    localparam logic [c_cnt_w-1:0]   c_wr_last  = c_cnt_w'(CL + BL - 2);
    localparam logic [COL_WIDTH-1:0] c_low_mask = COL_WIDTH'(BL - 1);

    logic                  r_cke_prev;
    logic                  r_busy;
    logic                  r_is_rd;
    logic                  r_auto;
    logic [BANK_WIDTH-1:0] r_bank;
    logic [ROW_WIDTH-1:0]  r_row;
    logic [COL_WIDTH-1:0]  r_col;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DQ_WIDTH-1:0]   r_mem [c_depth];
    logic [c_depth-1:0]    r_written;
    logic [DQ_WIDTH-1:0]   r_dq_out;
    logic                  r_dq_oe;
    logic                  r_err;
    err_e                  r_err_code;

    bank_state_e           w_state    [c_nbank];
    logic [ROW_WIDTH-1:0]  w_open_row [c_nbank];
    logic [c_nbank-1:0]    w_bank_act;
    logic [c_nbank-1:0]    w_bank_pre;
    logic [3:0]            w_cmd;
    logic                  w_cmd_en;
    logic                  w_sel_active;
    logic [c_cnt_w-1:0]    w_first;
    logic [c_cnt_w-1:0]    w_last;
    logic [c_cnt_w-1:0]    w_beat;
    logic                  w_busy;
    logic                  w_close;
    logic                  w_beat_on;
    logic [COL_WIDTH-1:0]  w_beat_col;
    logic [c_idx_w-1:0]    w_idx;
    logic [DQ_WIDTH-1:0]   w_rd_word;
    logic [DQ_WIDTH-1:0]   w_wr_word;
    logic                  w_act, w_pre, w_rd, w_wr, w_err;
    err_e                  w_code;

    assign w_cmd        = {cs_n, ras_n, cas_n, we_n};
    assign w_cmd_en     = cke && r_cke_prev && !cs_n;
    assign w_sel_active = (w_state[ba] == BANK_ACTIVE);

    // r_cnt equals the number of edges elapsed since the burst was accepted
    assign w_first   = r_is_rd ? c_rd_first : c_wr_first;
    assign w_last    = r_is_rd ? c_rd_last  : c_wr_last;
    assign w_beat    = r_cnt - w_first;
    assign w_busy    = r_busy && (r_cnt <= w_last);
    assign w_close   = r_busy && r_auto && (r_cnt == w_last + c_cnt_w'(1));
    assign w_beat_on = r_busy && (r_cnt >= w_first) && (r_cnt <= w_last);

    assign w_beat_col = (r_col & ~c_low_mask) |
                        ((r_col + COL_WIDTH'(w_beat)) & c_low_mask);
    assign w_idx      = {r_bank, r_row, w_beat_col};
    assign w_rd_word  = r_written[w_idx] ? r_mem[w_idx] : '0;

    always_comb begin
        w_wr_word = w_rd_word;
        for (int i = 0; i < DQ_WIDTH / 8; i++) begin
            if (!dm[i]) w_wr_word[8*i +: 8] = dq_in[8*i +: 8];
        end
    end

    always_comb begin
        w_act  = 1'b0;
        w_pre  = 1'b0;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_err  = 1'b0;
        w_code = ERR_NONE;
        if (w_cmd_en) begin
            case (w_cmd)
                CMD_ACT: begin
                    if (w_sel_active) begin
                        w_err  = 1'b1;
                        w_code = ERR_ACT_OPEN;
                    end else begin
                        w_act  = 1'b1;
                    end
                end
                CMD_PRE: begin
                    if (w_busy && (addr[10] || ba == r_bank)) begin
                        w_err  = 1'b1;
                        w_code = ERR_BUSY;
                    end else begin
                        w_pre  = 1'b1;
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (w_busy) begin
                        w_err  = 1'b1;
                        w_code = ERR_BUSY;
                    end else if (!w_sel_active) begin
                        w_err  = 1'b1;
                        w_code = ERR_NOT_OPEN;
                    end else if (w_cmd == CMD_RD) begin
                        w_rd   = 1'b1;
                    end else begin
                        w_wr   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar b = 0; b < c_nbank; b++) begin : g_bank
            assign w_bank_act[b] = w_act && (ba == BANK_WIDTH'(b));
            assign w_bank_pre[b] = (w_pre && (addr[10] || ba == BANK_WIDTH'(b))) ||
                                   (w_close && r_bank == BANK_WIDTH'(b));

            ddr2_bank_fsm #(
                .ROW_WIDTH (ROW_WIDTH)
            ) u_bank_fsm (
                .clk        (ck),
                .reset_n    (reset_n),
                .i_act      (w_bank_act[b]),
                .i_pre      (w_bank_pre[b]),
                .i_row      (addr[ROW_WIDTH-1:0]),
                .o_state    (w_state[b]),
                .o_open_row (w_open_row[b])
            );
        end
    endgenerate

    always_ff @(posedge ck) begin
        if (reset_n && w_beat_on && !r_is_rd) r_mem[w_idx] <= w_wr_word;
    end

    always_ff @(posedge ck) begin
        if (!reset_n) begin
            r_cke_prev <= 1'b0;
            r_busy     <= 1'b0;
            r_is_rd    <= 1'b0;
            r_auto     <= 1'b0;
            r_bank     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_cnt      <= '0;
            r_written  <= '0;
            r_dq_oe    <= 1'b0;
            r_dq_out   <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_cke_prev <= cke;
            r_err      <= w_err;
            if (w_err) r_err_code <= w_code;
            r_dq_oe  <= 1'b0;
            r_dq_out <= '0;
            if (w_beat_on) begin
                if (r_is_rd) begin
                    r_dq_oe  <= 1'b1;
                    r_dq_out <= w_rd_word;
                end else begin
                    r_written[w_idx] <= 1'b1;
                end
            end
            if (r_busy) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (r_cnt == w_last + c_cnt_w'(1)) r_busy <= 1'b0;
            end
            // A new burst may start on the same edge the previous one retires
            if (w_rd || w_wr) begin
                r_busy  <= 1'b1;
                r_is_rd <= w_rd;
                r_auto  <= addr[10];
                r_bank  <= ba;
                r_row   <= w_open_row[ba];
                r_col   <= addr[COL_WIDTH-1:0];
                r_cnt   <= c_cnt_w'(1);
            end
        end
    end

    assign dq_out   = r_dq_out;
    assign dq_oe    = r_dq_oe;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_mem_model.sv
`default_nettype none
// ============================================================================
// Module  : tb_ddr2_mem_model
// Brief   : Directed and random checks of ddr2_mem_model against a
//           timeline-based reference model.
// Revision: 1.0
// ============================================================================
module tb_ddr2_mem_model;

    localparam int CL = 4;
    localparam int BL = 8;

    logic        ck = 1'b0;
    logic        reset_n = 1'b0, cke = 1'b0;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] addr = '0;
    logic [15:0] dq_in = '0;
    logic [1:0]  dm = '0;
    logic [15:0] dq_out;
    logic        dq_oe, err;
    logic [2:0]  err_code;

    ddr2_mem_model dut (
        .ck (ck), .reset_n (reset_n), .cke (cke),
        .cs_n (cs_n), .ras_n (ras_n), .cas_n (cas_n), .we_n (we_n),
        .ba (ba), .addr (addr), .dq_in (dq_in), .dm (dm),
        .dq_out (dq_out), .dq_oe (dq_oe), .err (err), .err_code (err_code)
    );

    always #5 ck = ~ck;

    // Reference model: banks, memory image, and a per-edge expectation timeline
    int          errors = 0, checks = 0, n = 0, oe_seen = 0;
    logic [15:0] mm [2048];
    bit          mw [2048];
    bit          bo [4];
    logic [3:0]  brow [4];
    int          busy_until = -1, busy_bank = 0, close_edge = -1, close_bank = 0;
    bit          ckp = 0;
    bit          eo [4096];
    logic [15:0] ed [4096];
    bit          dv [4096];
    logic [15:0] dd [4096];
    logic [1:0]  ddm [4096];
    logic        exp_err = 0;
    logic [2:0]  exp_code = 0;
    logic [15:0] wdata [8];
    logic [1:0]  wdm [8];

    localparam logic [3:0] ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100,
                           PRE = 4'b0010, NOP = 4'b0111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(int b, int r, int c);
        return b * 512 + r * 32 + c;
    endfunction

    task automatic model_edge(input logic rn, input logic ce, input logic [3:0] c,
                              input logic [1:0] b, input logic [12:0] a);
        bit busy, do_close;
        int cb, col, id;
        logic [15:0] w;
        exp_err = 0;
        if (!rn) begin
            for (int i = 0; i < 4; i++) begin bo[i] = 0; brow[i] = 0; end
            for (int i = 0; i < 2048; i++) mw[i] = 0;
            for (int e = n; e < 4096; e++) begin eo[e] = 0; dv[e] = 0; end
            busy_until = -1; close_edge = -1; ckp = 0; exp_code = 0;
            return;
        end
        busy = (n <= busy_until);
        do_close = (n == close_edge);
        cb = close_bank;
        if (ce && ckp && !c[3]) begin
            case (c)
                ACT: if (bo[b]) exp_err = 1; else begin bo[b] = 1; brow[b] = a[3:0]; end
                PRE: begin
                    if (busy && (a[10] || b == busy_bank)) exp_err = 1;
                    else if (a[10]) for (int i = 0; i < 4; i++) bo[i] = 0;
                    else bo[b] = 0;
                    if (exp_err) exp_code = 3;
                end
                RD, WR: begin
                    if (busy) begin exp_err = 1; exp_code = 3; end
                    else if (!bo[b]) begin exp_err = 1; exp_code = 2; end
                    else begin
                        for (int k = 0; k < BL; k++) begin
                            col = (a[4:0] & ~7) | ((a[4:0] + k) & 7);
                            id = widx(b, brow[b], col);
                            if (c == RD) begin
                                eo[n + CL + k] = 1;
                                ed[n + CL + k] = mw[id] ? mm[id] : 16'h0;
                            end else begin
                                dv[n + CL - 1 + k] = 1;
                                dd[n + CL - 1 + k] = wdata[k];
                                ddm[n + CL - 1 + k] = wdm[k];
                                w = mw[id] ? mm[id] : 16'h0;
                                if (!wdm[k][0]) w[7:0] = wdata[k][7:0];
                                if (!wdm[k][1]) w[15:8] = wdata[k][15:8];
                                mm[id] = w; mw[id] = 1;
                            end
                        end
                        busy_until = (c == RD) ? n + CL + BL - 1 : n + CL + BL - 2;
                        busy_bank = b;
                        close_edge = a[10] ? busy_until + 1 : -1;
                        close_bank = b;
                    end
                end
                default: ;
            endcase
            if (exp_err && c == ACT) exp_code = 1;
        end
        ckp = ce;
        if (do_close) bo[cb] = 0;
    endtask

    task automatic step(input logic rn, input logic ce, input logic [3:0] c,
                        input logic [1:0] b, input logic [12:0] a);
        int e = n;
        reset_n = rn; cke = ce; {cs_n, ras_n, cas_n, we_n} = c; ba = b; addr = a;
        model_edge(rn, ce, c, b, a);
        dq_in = dv[e] ? dd[e] : 16'($urandom);
        dm    = dv[e] ? ddm[e] : 2'($urandom);
        @(posedge ck); #1;
        if (dq_oe) oe_seen++;
        chk("dq_oe", dq_oe, eo[e]);
        if (eo[e]) chk("dq_out", dq_out, ed[e]);
        chk("err", err, exp_err);
        chk("err_code", err_code, exp_code);
        n++;
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        step(1'b1, 1'b1, c, b, a);
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) cmd(NOP, 2'd0, 13'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step(1'b0, 1'b1, NOP, 2'd0, 13'd0);
        chk("rst_dq_out", dq_out, 16'h0);
        nops(1);

        // Write then read back 8 beats, count output-enable cycles
        cmd(ACT, 2'd1, 13'd3);
        for (int k = 0; k < 8; k++) begin wdata[k] = 16'h1111 * (k + 1); wdm[k] = 2'b00; end
        cmd(WR, 2'd1, 13'h004);
        nops(12);
        oe_seen = 0;
        cmd(RD, 2'd1, 13'h004);
        nops(3);
        chk("rd_before_cl", dq_oe, 1'b0);
        cmd(NOP, 2'd0, 13'd0);
        chk("rd_beat0", dq_out, 16'h1111);
        nops(12);
        chk("oe_len", oe_seen, 8);

        // Byte mask over prior data, wrapped burst order
        for (int k = 0; k < 8; k++) begin wdata[k] = 16'($urandom); wdm[k] = 2'b00; end
        wdata[0] = 16'hABCD;
        cmd(WR, 2'd1, 13'h006);
        nops(12);
        wdata[0] = 16'h12EF; wdm[0] = 2'b01;
        for (int k = 1; k < 8; k++) begin wdata[k] = 16'($urandom); wdm[k] = 2'($urandom); end
        cmd(WR, 2'd1, 13'h006);
        nops(12);
        cmd(RD, 2'd1, 13'h006);
        nops(4);
        chk("mask_beat0", dq_out, 16'h12CD);
        nops(9);

        // Read idle bank, activate open bank
        cmd(RD, 2'd2, 13'h000);
        chk("rd_idle_code", err_code, 3'd2);
        nops(6);
        cmd(ACT, 2'd1, 13'd5);
        chk("act_open_code", err_code, 3'd1);
        nops(1);

        // Auto-precharge read, then reactivation timing
        cmd(ACT, 2'd0, 13'd5);
        for (int k = 0; k < 8; k++) begin wdata[k] = 16'($urandom); wdm[k] = 2'b00; end
        cmd(WR, 2'd0, 13'h003);
        nops(12);
        cmd(RD, 2'd0, 13'h403);
        nops(4);
        cmd(ACT, 2'd0, 13'd7);
        chk("act_in_burst", err_code, 3'd1);
        nops(6);
        cmd(ACT, 2'd0, 13'd7);
        chk("act_at_close", err, 1'b1);
        cmd(ACT, 2'd0, 13'd7);
        chk("act_after_close", err, 1'b0);
        nops(2);

        // Clock-enable gating, then reset during a read
        step(1'b1, 1'b0, NOP, 2'd0, 13'd0);
        cmd(RD, 2'd1, 13'h000);
        nops(CL + 1);
        cmd(RD, 2'd1, 13'h000);
        nops(5);
        step(1'b0, 1'b1, NOP, 2'd0, 13'd0);
        chk("rst_mid_oe", dq_oe, 1'b0);
        nops(1);
        cmd(RD, 2'd1, 13'h000);
        chk("rd_after_rst", err_code, 3'd2);
        nops(3);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            int sel = $urandom_range(0, 15);
            logic [1:0] b = 2'($urandom);
            logic [12:0] a = 13'($urandom);
            logic ce = ($urandom_range(0, 19) != 0);
            if (sel <= 6) step(1'b1, ce, NOP, b, a);
            else if (sel <= 8) step(1'b1, ce, ACT, b, {9'd0, 2'd0, a[1:0]});
            else if (sel == 9) step(1'b1, ce, PRE, b, {2'b00, ($urandom_range(0, 3) == 0), a[9:0]});
            else if (sel <= 11) step(1'b1, ce, RD, b, a);
            else if (sel <= 13) begin
                for (int k = 0; k < 8; k++) begin
                    wdata[k] = 16'($urandom);
                    wdm[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                end
                step(1'b1, ce, WR, b, a);
            end else if (sel == 14) step(1'b1, ce, 4'($urandom_range(0, 15)), b, a);
            else step(($urandom_range(0, 7) != 0), ce, NOP, b, a);
        end
        nops(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
